// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the parameterised FIFO.
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 8;

    // Occupancy must represent 0..depth inclusive, hence one bit more than the address.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are never reset; the pointers alone define what is valid.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with registered read data, occupancy counter, status flags
// and sticky overflow/underflow error flags.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_on,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int CW = cnt_w(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam int AE_CLAMP = (AE_LEVEL > DEPTH) ? DEPTH : AE_LEVEL;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_CLAMP);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fifo_param: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_param: AF_LEVEL=%0d exceeds DEPTH=%0d", AF_LEVEL, DEPTH);
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              wr_acc, rd_acc, ram_we;

    // Request/accept: a request (wr_en/rd_en) is taken on an edge only when
    // fifo_on is high and the FIFO can serve it; otherwise it is dropped and,
    // if the FIFO was full/empty, latched as overflow/underflow.
    always_comb begin
        wr_acc = fifo_on && wr_en && !full;
        rd_acc = fifo_on && rd_en && !empty;
        ram_we = wr_acc && !rst;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q  | (fifo_on & wr_en & full);
        underflow_d  = underflow_q | (fifo_on & rd_en & empty);

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            dout_d       = ram_rdata;
            dout_valid_d = 1'b1;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_FULL);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of FIFO behaviour.
module tb_fifo_param;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_on = 1'b0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [CW-1:0]     count;
    logic              empty, full, almost_empty, almost_full, overflow, underflow;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_on      (fifo_on),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_dout = '0;
    bit                m_dv = 1'b0;
    bit                m_ovf = 1'b0;
    bit                m_udf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else if (!fifo_on) begin
            m_dv = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (exp_q.size() == DEPTH);
            was_empty = (exp_q.size() == 0);
            if (wr_en && was_full)  m_ovf = 1'b1;
            if (rd_en && was_empty) m_udf = 1'b1;
            m_dv = 1'b0;
            if (rd_en && !was_empty) begin
                m_dout = exp_q.pop_front();
                m_dv   = 1'b1;
            end
            if (wr_en && !was_full) exp_q.push_back(din);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            int n;
            n = exp_q.size();
            check("count",        count,        n);
            check("empty",        empty,        n == 0);
            check("full",         full,         n == DEPTH);
            check("almost_full",  almost_full,  n >= AF_LEVEL);
            check("almost_empty", almost_empty, n <= AE_LEVEL);
            check("overflow",     overflow,     m_ovf);
            check("underflow",    underflow,    m_udf);
            check("dout_valid",   dout_valid,   m_dv);
            check("dout",         dout,         m_dout);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit on, input bit w, input bit r, input logic [DATA_W-1:0] d);
        fifo_on = on;
        wr_en   = w;
        rd_en   = r;
        din     = d;
        @(negedge clk);
    endtask

    // Reset is applied with requests active to show it overrides everything.
    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        do_reset();
        check_en = 1'b1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);

        // fill to full, then overflow
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h10 + i);
            if (i == 4) check("af_at5", almost_full, 0);
            if (i == 5) check("af_at6", almost_full, 1);
        end
        check("fill_count", count, 8);
        check("fill_full", full, 1);
        cycle(1'b1, 1'b1, 1'b0, 32'h99);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 8);

        // drain in order, then underflow
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b1, '0);
            check("drain_dout", dout, 32'h10 + i);
            check("drain_dv", dout_valid, 1);
        end
        check("drain_empty", empty, 1);
        cycle(1'b1, 1'b0, 1'b1, '0);
        check("udf_set", underflow, 1);
        check("udf_dout_hold", dout, 32'h17);
        check("udf_dv", dout_valid, 0);

        // steady state at count 4 with pointer wrap
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h20 + i);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 32'h30 + i);
            check("rw_count", count, 4);
            check("rw_dout", dout, (i < 4) ? 32'h20 + i : 32'h30 + i - 4);
        end

        // full with simultaneous read and write: no write-through
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 32'h40 + i);
        cycle(1'b1, 1'b1, 1'b1, 32'hEE);
        check("fullrw_count", count, 7);
        check("fullrw_ovf", overflow, 1);
        check("fullrw_dout", dout, 32'h40);
        for (int i = 1; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b1, '0);
            check("fullrw_drain", dout, 32'h40 + i);
        end

        // disabled block freezes state; reset still works while disabled
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h50 + i);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 32'h60 + i);
            check("off_count", count, 3);
            check("off_dv", dout_valid, 0);
            check("off_ovf", overflow, 1);
            check("off_udf", underflow, 0);
        end
        rst = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, '0);
        rst = 1'b0;
        check("offrst_count", count, 0);
        check("offrst_ovf", overflow, 0);
        check("offrst_empty", empty, 1);

        // reset mid-operation discards data
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h70 + i);
        do_reset();
        check("midrst_empty", empty, 1);
        cycle(1'b1, 1'b1, 1'b0, 32'hAA);
        cycle(1'b1, 1'b0, 1'b1, '0);
        check("midrst_dout", dout, 32'hAA);
        check("midrst_dv", dout_valid, 1);

        // randomized traffic with varying write/read bias
        for (int blk = 0; blk < 6; blk++) begin
            int wp, rp;
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                end else begin
                    cycle($urandom_range(0, 9) != 0,
                          $urandom_range(0, 99) < wp,
                          $urandom_range(0, 99) < rp,
                          $urandom);
                end
            end
        end

        cycle(1'b0, 1'b0, 1'b0, '0);
        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
